// File: rtl/mem_pkg.sv
// Shared types and default sizes for the self-clearing synchronous memory.
package mem_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/mem_clr_seq.sv
// Clear-sweep address counter with terminal-count detect on the last address.
module mem_clr_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              run,
   output logic [ADDR_W-1:0] clr_addr,
   output logic              last
);

   logic [ADDR_W-1:0] cnt_reg;

   // Counter wraps naturally to 0 on the edge that writes the top address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (start) begin
         cnt_reg <= '0;
      end else if (run) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign clr_addr = cnt_reg;
   assign last     = run && (cnt_reg == '1);

endmodule

// File: rtl/mem_sync_clr.sv
// Single-port synchronous RAM with registered read and a sequential clear sweep
// that also runs after every reset; accesses during a sweep are dropped and flagged.
module mem_sync_clr
   import mem_pkg::*;
#(
   parameter int                DATA_W  = DEF_DATA_W,
   parameter int                ADDR_W  = DEF_ADDR_W,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              clr_req,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic              busy,
   output logic              err,
   inout  wire               dvdd,
   inout  wire               dgnd
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];

   state_t            state_reg;
   logic [DATA_W-1:0] dout_reg;
   logic              dout_vld_reg;
   logic              err_reg;

   logic              in_clear;
   logic              clr_start;
   logic              clr_last;
   logic [ADDR_W-1:0] clr_addr;
   logic              rd_en;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // Supply pins carry no logic; tie them off so they are visibly consumed.
   wire unused_supply = dvdd ^ dgnd;

   assign in_clear  = (state_reg == CLEAR);
   assign clr_start = !in_clear && clr_req;
   assign rd_en     = !in_clear && !clr_req && en && rw;

   mem_clr_seq #(
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (clr_start),
      .run      (in_clear),
      .clr_addr (clr_addr),
      .last     (clr_last)
   );

   // One write port shared by the sweep and user writes; never writes while in reset.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr;
      wr_data = din;
      if (in_clear) begin
         wr_en   = !rst;
         wr_addr = clr_addr;
         wr_data = CLR_VAL;
      end else if (en && !rw && !clr_req) begin
         wr_en = !rst;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= CLEAR;
         dout_reg     <= '0;
         dout_vld_reg <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clr_req) begin
                  state_reg    <= CLEAR;
                  dout_reg     <= '0;
                  dout_vld_reg <= 1'b0;
                  err_reg      <= en;
               end else begin
                  dout_vld_reg <= rd_en;
                  err_reg      <= 1'b0;
                  if (rd_en) begin
                     dout_reg <= mem_reg[addr];
                  end
               end
            end
            CLEAR: begin
               dout_vld_reg <= 1'b0;
               err_reg      <= en;
               if (clr_last) begin
                  state_reg <= IDLE;
               end
            end
            default: begin
               state_reg <= CLEAR;
            end
         endcase
      end
   end

   assign busy     = in_clear;
   assign dout     = dout_reg;
   assign dout_vld = dout_vld_reg;
   assign err      = err_reg;

endmodule

// File: doc/mem_sync_clr.md
MEM_SYNC_CLR -- requirements
Module: mem_sync_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, address width in bits; depth is fixed at DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter CLR_VAL, default all-zeros, DATA_W-bit word written by the clear sweep.
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-006 SHALL have port en  input  1  access enable.
REQ-007 SHALL have port rw  input  1  1 = read, 0 = write; qualified by en.
REQ-008 SHALL have port addr  input  ADDR_W  access address.
REQ-009 SHALL have port din  input  DATA_W  write data.
REQ-010 SHALL have port clr_req  input  1  single-cycle request to start a clear sweep.
REQ-011 SHALL have port dout  output  DATA_W  registered read data.
REQ-012 SHALL have port dout_vld  output  1  one-cycle pulse marking new dout.
REQ-013 SHALL have port busy  output  1  high while a clear sweep runs.
REQ-014 SHALL have port err  output  1  one-cycle pulse marking a dropped access.
REQ-015 SHALL have ports dvdd and dgnd  inout  1  digital supply and ground, with no logic function.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and CLEAR; busy SHALL be 1 exactly when the state is CLEAR (decoded from the state register).
REQ-017 In CLEAR, each rising edge SHALL write CLR_VAL to array[clr_addr] and increment clr_addr, an ADDR_W-bit counter.
REQ-018 The edge that writes address DEPTH-1 SHALL move the FSM to IDLE; a sweep SHALL therefore take exactly DEPTH cycles, and clr_addr SHALL wrap to 0.
REQ-019 In IDLE, en=1 with rw=1 SHALL load dout with array[addr] on the next edge and pulse dout_vld=1 for that one cycle (read latency 1).
REQ-020 In IDLE, en=1 with rw=0 SHALL write din to array[addr] on the next edge; dout and dout_vld SHALL be unaffected.
REQ-021 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-022 dout SHALL hold its last value when no read completes (no zeroing when idle).
REQ-023 In IDLE, clr_req=1 SHALL enter CLEAR on the next edge with clr_addr=0, and on that same edge SHALL clear dout and dout_vld to 0.
REQ-024 clr_req SHALL take priority over a same-cycle access (en=1): the access SHALL be dropped and err SHALL pulse 1 on the next cycle.
REQ-025 In CLEAR, any en=1 cycle SHALL be dropped (no array change, no dout change) and SHALL pulse err 1 on the next cycle.
REQ-026 In CLEAR, clr_req SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-027 en=0 SHALL cause no array or output change, and err SHALL be 0.

Reset
REQ-028 Asserting rst SHALL immediately set dout=0, dout_vld=0, err=0, clr_addr=0 and state=CLEAR (busy=1).
REQ-029 After rst is released, the first rising edge SHALL write address 0 and the sweep SHALL complete per REQ-018; reset SHALL never clear the array in a single cycle.
REQ-030 rst asserted mid-sweep or mid-access SHALL abort the operation and restart the sweep from address 0.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default parameter constants.
REQ-032 The clear address counter and its terminal-count detect SHALL be a sub-module, mem_clr_seq; the array and the access path SHALL stay in the top level.

Verification
REQ-033 Reset then release, default parameters -> busy=1 for exactly 256 cycles, then 0; reads of addresses 0x00, 0x7F and 0xFF return 0x00.
REQ-034 Write 0xA5 to 0x10, then read 0x10 the next cycle -> dout=0xA5 with dout_vld=1 for one cycle, one cycle after the read request.
REQ-035 Write 0x3C to 0xFF, pulse clr_req, and issue a read during the sweep -> err pulses once, dout=0x00; after busy falls, reading 0xFF returns 0x00.
REQ-036 clr_req and a write (en=1, rw=0, addr 0x20, din 0x77) in the same cycle -> err=1 next cycle, and after the sweep, reading 0x20 returns 0x00.
REQ-037 Assert rst at sweep address 0x80 -> outputs are 0 immediately, and after release busy lasts a full 256 cycles.
REQ-038 With DATA_W=16 and ADDR_W=4 -> the sweep takes 16 cycles, and write/read of 0xBEEF at address 0xF round-trips correctly.
